// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, baud divisors and receiver state encoding
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
  localparam int OS_RATE    = 16;
  localparam int DIV_W      = 9;

  // Full-bit divisors at 50 MHz, used by the transmitter
  localparam int TX_DIV_9600   = 5208;
  localparam int TX_DIV_19200  = 2604;
  localparam int TX_DIV_38400  = 1302;
  localparam int TX_DIV_57600  = 868;
  localparam int TX_DIV_115200 = 434;

  // 16x oversampling divisors at 50 MHz, used by the receiver
  localparam logic [DIV_W-1:0] OS_DIV_9600   = 9'd325;
  localparam logic [DIV_W-1:0] OS_DIV_19200  = 9'd163;
  localparam logic [DIV_W-1:0] OS_DIV_38400  = 9'd81;
  localparam logic [DIV_W-1:0] OS_DIV_57600  = 9'd54;
  localparam logic [DIV_W-1:0] OS_DIV_115200 = 9'd27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Unused baud_set codes fall back to 9600, matching the transmitter
  function automatic logic [DIV_W-1:0] os_div(input logic [2:0] baud_set);
    case (baud_set)
      3'd1:    return OS_DIV_19200;
      3'd2:    return OS_DIV_38400;
      3'd3:    return OS_DIV_57600;
      3'd4:    return OS_DIV_115200;
      default: return OS_DIV_9600;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - 16x oversampling tick generator with baud_set decode
module uart_os_tick
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] baud_set,
  output logic       tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_m1;

  assign div_m1 = os_div(baud_set) - 9'd1;
  assign tick   = en && (cnt == div_m1);

  // Divisor counter, parked at zero whenever the receiver is idle
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == div_m1) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 9'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and 3-sample majority vote
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx: SYNC_STAGES must be at least 2");
  end
  if (CLK_HZ != 50000000) begin : g_bad_clk
    $error("uart_rx: divisor table is only valid for a 50 MHz clock");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_d;
  logic                   start_edge;
  rx_state_t              state;
  logic [2:0]             baud_q;
  logic [3:0]             sc;
  logic [2:0]             bit_idx;
  logic [1:0]             samp;
  logic                   bit_q;
  logic                   bit_maj;
  logic [DATA_BITS-1:0]   shreg;
  logic                   os_en;
  logic                   tick;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = rx_d & ~rx_s;
  assign os_en      = (state != IDLE);
  // Third vote is the live sample, so a bit resolves on the sc=9 tick itself
  assign bit_maj    = maj3(samp[0], samp[1], rx_s);

  // Metastability chain on the asynchronous line, resets to the idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rs232_rx};
      rx_d   <= rx_s;
    end
  end

  uart_os_tick u_os_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (os_en),
    .baud_set (baud_q),
    .tick     (tick)
  );

  // Frame state machine: samples at sc 7/8/9, advances bits at sc 15, resolves stop mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_q     <= '0;
      sc         <= '0;
      bit_idx    <= '0;
      samp       <= '0;
      bit_q      <= 1'b0;
      shreg      <= '0;
      data_byte  <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        sc <= sc + 4'd1;
        if (sc == 4'd7) samp[0] <= rx_s;
        if (sc == 4'd8) samp[1] <= rx_s;
        if (sc == 4'd9) bit_q   <= bit_maj;
      end
      case (state)
        IDLE: begin
          sc <= '0;
          if (start_edge) begin
            state      <= START;
            uart_state <= 1'b1;
            baud_q     <= baud_set;
          end
        end
        START: begin
          if (tick && sc == 4'd15) begin
            if (!bit_q) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state      <= IDLE;
              uart_state <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick && sc == 4'd15) begin
            shreg[bit_idx] <= bit_q;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick && sc == 4'd9) begin
            state      <= IDLE;
            uart_state <= 1'b0;
            if (bit_maj) begin
              data_byte <= shreg;
              rx_done   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam real CLK_PER = 20.0;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs232_rx;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  logic [7:0] got [0:15];

  real bt115;
  real bt57;
  real bt38;
  real bt96;

  uart_rx #(
    .CLK_HZ      (50000000),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs232_rx   (rs232_rx),
    .baud_set   (baud_set),
    .data_byte  (data_byte),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  always #10 clk = ~clk;

  // Strobe monitor: counts every cycle each strobe is high and records received bytes
  always @(negedge clk) begin
    if (rx_done) begin
      if (done_cnt < 16) got[done_cnt] = data_byte;
      done_cnt++;
    end
    if (frame_err) fe_cnt++;
    if (rx_done && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame; glitch_bit selects a data bit that gets a 1/16-bit inversion centred on its sc=8 sample
  task automatic send_frame(input logic [7:0] b, input real bt, input logic stop_val, input int glitch_bit);
    rs232_rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      if (i == glitch_bit) begin
        #(bt * 8.5 / 16.0);
        rs232_rx = ~b[i];
        #(bt / 16.0);
        rs232_rx = b[i];
        #(bt * 6.5 / 16.0);
      end else begin
        #(bt);
      end
    end
    rs232_rx = stop_val;
    #(bt);
    rs232_rx = 1'b1;
  endtask

  initial begin
    bt115 = 27.0 * 16.0 * CLK_PER;
    bt57  = 54.0 * 16.0 * CLK_PER;
    bt38  = 81.0 * 16.0 * CLK_PER;
    bt96  = 325.0 * 16.0 * CLK_PER;

    rst      = 1'b1;
    rs232_rx = 1'b1;
    baud_set = 3'd4;
    repeat (5) @(negedge clk);
    check("reset_data_byte", data_byte, 8'h00);
    check("reset_rx_done", rx_done, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_uart_state", uart_state, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 0x55 at 115200, ideal timing
    send_frame(8'h55, bt115, 1'b1, -1);
    #(bt115 * 2.0);
    @(negedge clk);
    check("b55_done_count", done_cnt, 1);
    check("b55_byte", got[0], 8'h55);
    check("b55_data_byte", data_byte, 8'h55);
    check("b55_no_frame_err", fe_cnt, 0);
    check("b55_state_idle", uart_state, 1'b0);

    // 0xA3 then 0x0F back to back, no gap after the stop bit
    send_frame(8'hA3, bt115, 1'b1, -1);
    send_frame(8'h0F, bt115, 1'b1, -1);
    #(bt115 * 2.0);
    @(negedge clk);
    check("b2b_done_count", done_cnt, 3);
    check("b2b_first", got[1], 8'hA3);
    check("b2b_second", got[2], 8'h0F);

    // Low glitch of 4/16 bit at 57600 on an idle line
    baud_set = 3'd3;
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (100) @(negedge clk);
    check("glitch_in_start", uart_state, 1'b1);
    repeat (116) @(negedge clk);
    rs232_rx = 1'b1;
    #(bt57 * 2.0);
    @(negedge clk);
    check("glitch_state_idle", uart_state, 1'b0);
    check("glitch_no_done", done_cnt, 3);
    check("glitch_no_frame_err", fe_cnt, 0);
    check("glitch_data_kept", data_byte, 8'h0F);

    // 0xC4 at 38400 with the stop bit forced low
    baud_set = 3'd2;
    send_frame(8'hC4, bt38, 1'b0, -1);
    #(bt38 * 2.0);
    @(negedge clk);
    check("stop0_frame_err", fe_cnt, 1);
    check("stop0_no_done", done_cnt, 3);
    check("stop0_data_kept", data_byte, 8'h0F);

    // 0x3C with sender 2% slow, 2% fast, then a single-sample glitch on bit 2
    baud_set = 3'd3;
    send_frame(8'h3C, bt57 * 1.02, 1'b1, -1);
    #(bt57 * 2.0);
    @(negedge clk);
    check("slow_done_count", done_cnt, 4);
    check("slow_byte", got[3], 8'h3C);
    send_frame(8'h3C, bt57 * 0.98, 1'b1, -1);
    #(bt57 * 2.0);
    @(negedge clk);
    check("fast_done_count", done_cnt, 5);
    check("fast_byte", got[4], 8'h3C);
    send_frame(8'h3C, bt57, 1'b1, 2);
    #(bt57 * 2.0);
    @(negedge clk);
    check("vote_done_count", done_cnt, 6);
    check("vote_byte", got[5], 8'h3C);
    check("vote_no_frame_err", fe_cnt, 1);

    // Reset during bit 4 of 0x96 (bits LSB first: 0 1 1 0 1 ...), then 0x69
    baud_set = 3'd4;
    rs232_rx = 1'b0;
    #(bt115);
    rs232_rx = 1'b0; #(bt115);
    rs232_rx = 1'b1; #(bt115);
    rs232_rx = 1'b1; #(bt115);
    rs232_rx = 1'b0; #(bt115);
    rs232_rx = 1'b1;
    #(bt115 / 2.0);
    @(negedge clk);
    check("abort_busy_before_rst", uart_state, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_state_idle", uart_state, 1'b0);
    #(bt115 * 12.0);
    @(negedge clk);
    check("abort_no_done", done_cnt, 6);
    check("abort_no_frame_err", fe_cnt, 1);
    send_frame(8'h69, bt115, 1'b1, -1);
    #(bt115 * 2.0);
    @(negedge clk);
    check("after_rst_done_count", done_cnt, 7);
    check("after_rst_byte", got[6], 8'h69);

    // baud_set=7 decodes as 9600; baud_set change mid-frame must be ignored
    baud_set = 3'd7;
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (10) @(negedge clk);
    baud_set = 3'd4;
    repeat (422) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (4568) @(negedge clk);
    check("b7_still_in_start", uart_state, 1'b1);
    repeat (400) @(negedge clk);
    check("b7_start_rejected", uart_state, 1'b0);
    #(bt96 * 0.1);
    @(negedge clk);
    check("b7_no_done", done_cnt, 7);
    check("b7_no_frame_err", fe_cnt, 1);

    check("strobes_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
